// File: rtl/hex_keypad_entry_if.sv
// hex_keypad_entry_if: keypad matrix and entry-value signals shared between the scanner and its consumer.
interface hex_keypad_entry_if;
  logic [3:0] row_in;
  logic clear;
  logic [3:0] col_out;
  logic [15:0] data;
  logic [3:0] key_code;
  logic key_valid;
  modport master (input row_in, clear, output col_out, data, key_code, key_valid);
  modport slave (output row_in, clear, input col_out, data, key_code, key_valid);
endinterface

// File: rtl/hex_keypad_entry.sv
// hex_keypad_entry: scans a 4x4 hex keypad, debounces whole scan frames and shifts accepted digits into a 16-bit value.
module hex_keypad_entry #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input logic clk,
  input logic reset,
  hex_keypad_entry_if.master kp
);
  localparam int DW = $clog2(SCAN_DIV);
  typedef enum logic [1:0] {IDLE, PEND, HELD, REL} state_t;
  state_t state_q, state_d;
  logic [3:0] row_s1_q, row_s2_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0] col_q, col_d;
  logic [1:0] seen_q, seen_d;
  logic [3:0] seen_key_q, seen_key_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] key_code_q, key_code_d;
  logic [15:0] data_q, data_d;
  logic key_valid_q, key_valid_d;
  logic [3:0] lo;
  logic [2:0] n;
  logic [1:0] r, tot;
  logic [3:0] key_now;
  logic sample, frame_end, accept;
  // seen/tot encode the frame so far: 0 = nothing, 1 = exactly one key, 2 = more than one
  always_comb begin
    lo = ~row_s2_q;
    n = {2'b0, lo[0]} + {2'b0, lo[1]} + {2'b0, lo[2]} + {2'b0, lo[3]};
    r = lo[3] ? 2'd3 : lo[2] ? 2'd2 : lo[1] ? 2'd1 : 2'd0;
    sample = dwell_q == DW'(SCAN_DIV - 1);
    frame_end = sample && col_q == 2'd0;
    tot = (seen_q == 2'd0) ? ((n > 3'd1) ? 2'd2 : n[1:0]) : ((n != 3'd0) ? 2'd2 : seen_q);
    key_now = (seen_q == 2'd0) ? {r, col_q} : seen_key_q;
    dwell_d = sample ? '0 : dwell_q + 1'b1;
    col_d = sample ? col_q - 2'd1 : col_q;
    seen_d = sample ? (frame_end ? 2'd0 : tot) : seen_q;
    seen_key_d = sample ? key_now : seen_key_q;
    state_d = state_q;
    cand_d = cand_q;
    cnt_d = cnt_q;
    accept = 1'b0;
    if (frame_end)
      case (state_q)
        IDLE: if (tot == 2'd1) begin
          cand_d = key_now;
          cnt_d = 4'd1;
          accept = DEBOUNCE == 1;
          state_d = (DEBOUNCE == 1) ? HELD : PEND;
        end
        PEND: if (tot != 2'd1) state_d = IDLE;
          else if (key_now != cand_q) begin
            cand_d = key_now;
            cnt_d = 4'd1;
          end else begin
            cnt_d = cnt_q + 4'd1;
            accept = cnt_d == 4'(DEBOUNCE);
            state_d = accept ? HELD : PEND;
          end
        HELD: if (tot == 2'd0) begin
          cnt_d = 4'd1;
          state_d = (DEBOUNCE == 1) ? IDLE : REL;
        end
        REL: if (tot != 2'd0) state_d = HELD;
          else begin
            cnt_d = cnt_q + 4'd1;
            state_d = (cnt_d == 4'(DEBOUNCE)) ? IDLE : REL;
          end
      endcase
    key_valid_d = accept;
    key_code_d = accept ? key_now : key_code_q;
    data_d = accept ? {kp.clear ? 12'h000 : data_q[11:0], key_now} : kp.clear ? 16'h0000 : data_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      row_s1_q <= 4'hf;
      row_s2_q <= 4'hf;
      dwell_q <= '0;
      col_q <= 2'd3;
      seen_q <= 2'd0;
      seen_key_q <= 4'h0;
      cand_q <= 4'h0;
      cnt_q <= 4'h0;
      key_code_q <= 4'h0;
      data_q <= 16'h0000;
      key_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_s1_q <= kp.row_in;
      row_s2_q <= row_s1_q;
      dwell_q <= dwell_d;
      col_q <= col_d;
      seen_q <= seen_d;
      seen_key_q <= seen_key_d;
      cand_q <= cand_d;
      cnt_q <= cnt_d;
      key_code_q <= key_code_d;
      data_q <= data_d;
      key_valid_q <= key_valid_d;
    end
  end
  assign kp.col_out = ~(4'b0001 << col_q);
  assign kp.data = data_q;
  assign kp.key_code = key_code_q;
  assign kp.key_valid = key_valid_q;
endmodule

// File: tb/tb_hex_keypad_entry.sv
// tb_hex_keypad_entry: directed scenarios against a keypad matrix model with SCAN_DIV=4, DEBOUNCE=2.
module tb_hex_keypad_entry;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [15:0] pressed = 16'h0000;
  int checks = 0;
  int passes = 0;
  int pulses = 0;
  hex_keypad_entry_if kif();
  hex_keypad_entry #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (.clk(clk), .reset(reset), .kp(kif));
  always #5 clk = ~clk;
  // a pressed key pulls its row low while its column is strobed
  always_comb begin
    kif.row_in = 4'hf;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (pressed[4*rr+cc] && !kif.col_out[cc]) kif.row_in[rr] = 1'b0;
  end
  always @(negedge clk) if (kif.key_valid === 1'b1) pulses++;
  task automatic frames(input int nf);
    repeat (16 * nf) @(posedge clk);
    @(negedge clk);
  endtask
  task automatic align();
    int k = 0;
    while (kif.col_out !== 4'b1110 && k < 40) begin @(negedge clk); k++; end
    while (kif.col_out !== 4'b0111 && k < 80) begin @(negedge clk); k++; end
    checks++;
    if (k >= 80) $display("FAIL align: col_out=%b never reached frame start", kif.col_out); else passes++;
  endtask
  task automatic do_clear();
    @(negedge clk) kif.clear = 1'b1;
    @(negedge clk) kif.clear = 1'b0;
    checks++;
    if (kif.data !== 16'h0000) $display("FAIL clear: data=%h exp 0000", kif.data); else passes++;
  endtask
  task automatic enter_key(input logic [3:0] key, input logic [15:0] exp_data);
    pressed = 16'h0001 << key;
    repeat (31) @(posedge clk);
    @(negedge clk);
    checks++;
    if (kif.key_valid !== 1'b0) $display("FAIL enter_early key %h: key_valid=%b exp 0", key, kif.key_valid); else passes++;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (kif.key_valid !== 1'b1) $display("FAIL enter_pulse key %h: key_valid=%b exp 1", key, kif.key_valid); else passes++;
    checks++;
    if (kif.key_code !== key) $display("FAIL enter_code: key_code=%h exp %h", kif.key_code, key); else passes++;
    checks++;
    if (kif.data !== exp_data) $display("FAIL enter_data: data=%h exp %h", kif.data, exp_data); else passes++;
  endtask
  task automatic test_reset();
    logic [3:0] exp;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({kif.col_out, kif.data, kif.key_code, kif.key_valid} !== {4'b0111, 16'h0000, 4'h0, 1'b0})
      $display("FAIL reset_vals: col=%b data=%h code=%h kv=%b exp 0111 0000 0 0", kif.col_out, kif.data, kif.key_code, kif.key_valid);
    else passes++;
    reset = 1'b1;
    for (int k = 0; k < 32; k++) begin
      exp = ~(4'b0001 << (3 - (k / 4) % 4));
      checks++;
      if (kif.col_out !== exp) $display("FAIL scan cycle %0d: col_out=%b exp %b", k, kif.col_out, exp); else passes++;
      @(negedge clk);
    end
    checks++;
    if (pulses !== 0 || kif.data !== 16'h0000) $display("FAIL idle_quiet: pulses=%0d data=%h exp 0 0000", pulses, kif.data); else passes++;
  endtask
  task automatic test_single();
    int p0;
    align();
    p0 = pulses;
    enter_key(4'h6, 16'h0006);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (kif.key_valid !== 1'b0) $display("FAIL single_width: key_valid=%b exp 0", kif.key_valid); else passes++;
    repeat (62) @(posedge clk);
    @(negedge clk);
    checks++;
    if (pulses !== p0 + 1) $display("FAIL single_count: pulses=%0d exp %0d", pulses - p0, 1); else passes++;
    pressed = 16'h0000;
    frames(3);
  endtask
  task automatic test_bounce();
    int p0;
    align();
    p0 = pulses;
    pressed = 16'h0002;
    frames(1);
    pressed = 16'h0000;
    frames(1);
    checks++;
    if (pulses !== p0) $display("FAIL bounce_nopulse: pulses=%0d exp 0", pulses - p0); else passes++;
    enter_key(4'h1, 16'h0061);
    pressed = 16'h0000;
    frames(3);
    checks++;
    if (pulses !== p0 + 1) $display("FAIL bounce_count: pulses=%0d exp 1", pulses - p0); else passes++;
  endtask
  task automatic test_sequence();
    do_clear();
    align();
    enter_key(4'h1, 16'h0001); pressed = 16'h0000; frames(3);
    enter_key(4'h2, 16'h0012); pressed = 16'h0000; frames(3);
    enter_key(4'h3, 16'h0123); pressed = 16'h0000; frames(3);
    enter_key(4'ha, 16'h123a); pressed = 16'h0000; frames(3);
    enter_key(4'hf, 16'h23af); pressed = 16'h0000; frames(3);
    checks++;
    if (kif.data !== 16'h23af) $display("FAIL seq_final: data=%h exp 23af", kif.data); else passes++;
  endtask
  task automatic test_multi();
    int p0;
    align();
    p0 = pulses;
    pressed = 16'h0060;
    frames(4);
    checks++;
    if (pulses !== p0) $display("FAIL multi_nopulse: pulses=%0d exp 0", pulses - p0); else passes++;
    enter_key(4'h6, 16'h3af6);
    pressed = 16'h0060;
    frames(2);
    pressed = 16'h0040;
    frames(2);
    checks++;
    if (pulses !== p0 + 1) $display("FAIL multi_count: pulses=%0d exp 1", pulses - p0); else passes++;
    checks++;
    if (kif.key_code !== 4'h6 || kif.data !== 16'h3af6) $display("FAIL multi_hold: code=%h data=%h exp 6 3af6", kif.key_code, kif.data); else passes++;
    pressed = 16'h0000;
    frames(3);
  endtask
  task automatic test_clear_accept();
    do_clear();
    align();
    enter_key(4'h1, 16'h0001); pressed = 16'h0000; frames(3);
    enter_key(4'h2, 16'h0012); pressed = 16'h0000; frames(3);
    enter_key(4'h3, 16'h0123); pressed = 16'h0000; frames(3);
    enter_key(4'h4, 16'h1234); pressed = 16'h0000; frames(3);
    pressed = 16'h0200;
    repeat (31) @(posedge clk);
    @(negedge clk) kif.clear = 1'b1;
    @(posedge clk);
    @(negedge clk) kif.clear = 1'b0;
    checks++;
    if ({kif.key_valid, kif.key_code, kif.data} !== {1'b1, 4'h9, 16'h0009})
      $display("FAIL clear_accept: kv=%b code=%h data=%h exp 1 9 0009", kif.key_valid, kif.key_code, kif.data);
    else passes++;
    pressed = 16'h0000;
    frames(3);
  endtask
  task automatic test_reset_pend();
    int p0;
    align();
    p0 = pulses;
    pressed = 16'h0008;
    frames(1);
    repeat (8) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({kif.col_out, kif.data, kif.key_code, kif.key_valid} !== {4'b0111, 16'h0000, 4'h0, 1'b0} || pulses !== p0)
      $display("FAIL reset_pend: col=%b data=%h code=%h kv=%b pulses=%0d exp 0111 0000 0 0 0", kif.col_out, kif.data, kif.key_code, kif.key_valid, pulses - p0);
    else passes++;
    reset = 1'b1;
    repeat (31) @(posedge clk);
    @(negedge clk);
    checks++;
    if (kif.key_valid !== 1'b0 || pulses !== p0) $display("FAIL rearm_early: kv=%b pulses=%0d exp 0 0", kif.key_valid, pulses - p0); else passes++;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({kif.key_valid, kif.key_code, kif.data} !== {1'b1, 4'h3, 16'h0003})
      $display("FAIL rearm_accept: kv=%b code=%h data=%h exp 1 3 0003", kif.key_valid, kif.key_code, kif.data);
    else passes++;
    pressed = 16'h0000;
    frames(3);
  endtask
  initial begin
    kif.clear = 1'b0;
    test_reset();
    test_single();
    test_bounce();
    test_sequence();
    test_multi();
    test_clear_accept();
    test_reset_pend();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
